idct4_transpose_buf: RTL and testbench
======================================

Name: idct4_transpose_buf

Overview:
- Transpose buffer between the first (column) and second (row) pass of the 4x4 inverse DCT.
- Accepts first-pass results one sample per cycle in raster order and clips each to the intermediate width.
- Presents each stored 4x4 block column by column, four samples per beat, in the format the 4-input IDCT MAC stage consumes.
- Ping-pong storage: one block can fill while the previous block drains.

Parameters:
- DATA_W, 25: width of in_data and of each out_d* sample (signed).
- CLIP_W, 16: intermediate clip width. Inputs saturate to signed CLIP_W bits, then sign-extend to DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  signed first-pass sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  buffer can accept a sample this cycle.
- out_d1  out  DATA_W  row 0 of the current column.
- out_d2  out  DATA_W  row 1 of the current column.
- out_d3  out  DATA_W  row 2 of the current column.
- out_d4  out  DATA_W  row 3 of the current column.
- out_valid  out  1  out_d1..out_d4 hold a valid column.
- out_ready  in  1  downstream accepts the column.
- out_last  out  1  current beat is column 3, the last of its block.
- sat_pulse  out  1  one-cycle pulse: the sample accepted in the previous cycle was clipped.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - full[1:0]=0, wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0.
  - sat_pulse=0, out_valid=0, out_last=0, out_d*=0, in_ready=1.
- Storage contents are not reset.
- Reset mid-block discards all partial and full blocks. The first accepted sample after release is sample 0 of a new block.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept when in_valid && in_ready. Sample k = wr_cnt (0..15) goes to row k/4, column k%4 of bank wr_bank.
  - Stored value: +(2^(CLIP_W-1)-1) if input is above it; -(2^(CLIP_W-1)) if input is below it; otherwise the input. Result is sign-extended to DATA_W.
  - sat_pulse is registered: high exactly one cycle after a clipped sample is accepted.
  - On accepting sample 15: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0. Otherwise wr_cnt increments.
  - in_valid while in_ready=0: sample is not taken and no state changes. The upstream stage must hold the sample.
- Read side:
  - out_valid = full[rd_bank].
  - out_d1..out_d4 = rows 0..3 of column rd_cnt in bank rd_bank, combinational from storage. All four are 0 when out_valid=0.
  - out_last = out_valid && rd_cnt==3.
  - Beat transfers when out_valid && out_ready.
  - On beat with rd_cnt==3: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0. Otherwise rd_cnt increments.
  - Outputs are stable while out_valid && !out_ready.
- Latency: sample 15 accepted at edge N gives out_valid=1 after edge N; the first column is visible in cycle N+1.
- Throughput: one block per 16 cycles sustained when out_ready=1.
- Simultaneous events:
  - A write-side set and a read-side clear never target the same bank in one cycle. The write bank is never full and the read bank always is.
  - Freeing a bank on the final read beat updates in_ready from the next cycle only. There is no combinational path from out_ready to in_ready.
- Both banks full: in_ready=0 until the read side finishes its block.

Decomposition:
- Shared package idct_pkg:
  - IDCT_DATA_W=25, IDCT_CLIP_W=16, IDCT_N=4.
  - A sat_clip function: signed saturation from DATA_W to CLIP_W with sign extension.
- The same package is reused by the IDCT stage.
- One natural sub-module, idct4_bank: a 16x DATA_W register array with a raster write port and a 4-wide column read port. It is instantiated twice.
- Control (counters, full flags, handshake) stays in the top.

Test Plan:
- Single block:
  - Stimulus: feed 0..15 with out_ready=1.
  - Response: beats (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15). out_last only on the 4th beat. First beat in the cycle after sample 15.
- Clipping:
  - Stimulus: samples 40000, -40000, 32767, -32768.
  - Response: stored 32767, -32768, 32767, -32768. sat_pulse high after samples 0 and 1 only.
- Back-pressure:
  - Stimulus: out_ready=0, stream 3 blocks.
  - Response: in_ready falls after sample 31. Block 3 stalls. Raising out_ready drains block 0 then block 1, data intact.
- Hold under stall:
  - Stimulus: toggle out_ready 1,0,0,1.
  - Response: out_d* and out_last constant during the stalled cycles.
- Continuous stream:
  - Stimulus: 8 blocks with in_valid=1, out_ready=1.
  - Response: in_ready never drops. 32 beats, correct ordering.
- Reset mid-block:
  - Stimulus: assert reset after sample 9 of block 1 while block 0 is draining.
  - Response: out_valid=0 and out_d*=0 immediately, in_ready=1. A following block reads out correctly from sample 0.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared definitions for the 4x4 inverse DCT datapath.
//
// The transpose buffer and the IDCT MAC stage both import this package,
// so the widths and the intermediate saturation rule are defined once.
//
// Contents:
//   IDCT_DATA_W  width of first-pass samples and MAC-stage inputs
//   IDCT_CLIP_W  intermediate clip width between the two passes
//   IDCT_N       transform size (4x4 blocks)
//   sat_clip()   signed saturation from IDCT_DATA_W to IDCT_CLIP_W,
//                sign-extended back to IDCT_DATA_W
//   is_clipped() true when sat_clip() would change its argument

package idct_pkg;

   localparam int IDCT_DATA_W = 25;
   localparam int IDCT_CLIP_W = 16;
   localparam int IDCT_N      = 4;

   localparam logic signed [IDCT_DATA_W-1:0] IDCT_CLIP_MAX =
      IDCT_DATA_W'((64'sd1 <<< (IDCT_CLIP_W - 1)) - 64'sd1);
   localparam logic signed [IDCT_DATA_W-1:0] IDCT_CLIP_MIN =
      IDCT_DATA_W'(-(64'sd1 <<< (IDCT_CLIP_W - 1)));

   function automatic logic signed [IDCT_DATA_W-1:0] sat_clip(
      input logic signed [IDCT_DATA_W-1:0] x
   );
      if (x > IDCT_CLIP_MAX) begin
         return IDCT_CLIP_MAX;
      end else if (x < IDCT_CLIP_MIN) begin
         return IDCT_CLIP_MIN;
      end
      return x;
   endfunction

   function automatic logic is_clipped(
      input logic signed [IDCT_DATA_W-1:0] x
   );
      return (x > IDCT_CLIP_MAX) || (x < IDCT_CLIP_MIN);
   endfunction

endpackage

// File: rtl/idct4_bank.sv
// One 4x4 block of transpose storage.
//
// Samples are written one at a time in raster order (address = row*4 + col)
// and read back a whole column at a time, which is the transpose the second
// IDCT pass needs. The array is deliberately not reset: its contents are only
// ever observed after a full block has been written.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write wr_data to wr_addr this cycle
//   wr_addr  raster address, row in [3:2], column in [1:0]
//   wr_data  sample to store
//   rd_col   column to present on rd_data
//   rd_data  rows 0..3 of column rd_col (combinational)

module idct4_bank
   import idct_pkg::*;
#(
   parameter int DATA_W = IDCT_DATA_W
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [3:0]               wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [1:0]               rd_col,
   output logic signed [DATA_W-1:0] rd_data [IDCT_N]
);

   logic signed [DATA_W-1:0] mem [IDCT_N*IDCT_N];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      for (int r = 0; r < IDCT_N; r++) begin
         rd_data[r] = mem[4'(r * IDCT_N) + {2'b00, rd_col}];
      end
   end

endmodule

// File: rtl/idct4_transpose_buf.sv
// Ping-pong transpose buffer between the column and row passes of the
// 4x4 inverse DCT.
//
// First-pass samples arrive one per cycle in raster order, are saturated to
// CLIP_W bits (sign-extended back to DATA_W) and written into the current
// write bank. A completed bank is presented column by column, four samples
// per beat, while the other bank fills.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    signed first-pass sample
//   in_valid   in_data is valid
//   in_ready   a sample can be accepted this cycle
//   out_d1..4  rows 0..3 of the current column (0 when out_valid is low)
//   out_valid  a column is being presented
//   out_ready  downstream accepts the column
//   out_last   current beat is column 3 of its block
//   sat_pulse  the sample accepted in the previous cycle was clipped

module idct4_transpose_buf
   import idct_pkg::*;
#(
   parameter int DATA_W = IDCT_DATA_W,
   parameter int CLIP_W = IDCT_CLIP_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_d1,
   output logic signed [DATA_W-1:0] out_d2,
   output logic signed [DATA_W-1:0] out_d3,
   output logic signed [DATA_W-1:0] out_d4,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     sat_pulse
);

   localparam logic signed [DATA_W-1:0] CLIP_MAX =
      DATA_W'((64'sd1 <<< (CLIP_W - 1)) - 64'sd1);
   localparam logic signed [DATA_W-1:0] CLIP_MIN =
      DATA_W'(-(64'sd1 <<< (CLIP_W - 1)));

   logic [1:0] full;
   logic [1:0] full_next;
   logic       wr_bank;
   logic [3:0] wr_cnt;
   logic       rd_bank;
   logic [1:0] rd_cnt;

   logic                     accept;
   logic                     beat;
   logic                     wr_done;
   logic                     rd_done;
   logic                     clip_hi;
   logic                     clip_lo;
   logic signed [DATA_W-1:0] clipped;

   logic signed [DATA_W-1:0] bank_d [2][IDCT_N];
   logic signed [DATA_W-1:0] col_d  [IDCT_N];

   // Write side

   assign in_ready = !full[wr_bank];
   assign accept   = in_valid && in_ready;
   assign wr_done  = accept && (wr_cnt == 4'd15);

   assign clip_hi = in_data > CLIP_MAX;
   assign clip_lo = in_data < CLIP_MIN;

   always_comb begin
      clipped = in_data;
      if (clip_hi) begin
         clipped = CLIP_MAX;
      end else if (clip_lo) begin
         clipped = CLIP_MIN;
      end
   end

   // Read side

   assign out_valid = full[rd_bank];
   assign beat      = out_valid && out_ready;
   assign rd_done   = beat && (rd_cnt == 2'd3);
   assign out_last  = out_valid && (rd_cnt == 2'd3);

   // The write bank is never full and the read bank always is whenever
   // either side touches its flag, so set and clear never collide.
   always_comb begin
      full_next = full;
      if (wr_done) begin
         full_next[wr_bank] = 1'b1;
      end
      if (rd_done) begin
         full_next[rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         wr_cnt    <= 4'd0;
         rd_bank   <= 1'b0;
         rd_cnt    <= 2'd0;
         sat_pulse <= 1'b0;
      end else begin
         full      <= full_next;
         sat_pulse <= accept && (clip_hi || clip_lo);

         if (accept) begin
            if (wr_done) begin
               wr_bank <= ~wr_bank;
               wr_cnt  <= 4'd0;
            end else begin
               wr_cnt <= wr_cnt + 4'd1;
            end
         end

         if (beat) begin
            if (rd_done) begin
               rd_bank <= ~rd_bank;
               rd_cnt  <= 2'd0;
            end else begin
               rd_cnt <= rd_cnt + 2'd1;
            end
         end
      end
   end

   // Storage

   for (genvar b = 0; b < 2; b++) begin : g_bank
      idct4_bank #(
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .wr_en   (accept && (wr_bank == 1'(b))),
         .wr_addr (wr_cnt),
         .wr_data (clipped),
         .rd_col  (rd_cnt),
         .rd_data (bank_d[b])
      );
   end

   // Forced to zero when idle so stale bank contents never leak downstream.
   always_comb begin
      for (int r = 0; r < IDCT_N; r++) begin
         col_d[r] = '0;
         if (out_valid) begin
            col_d[r] = rd_bank ? bank_d[1][r] : bank_d[0][r];
         end
      end
   end

   assign out_d1 = col_d[0];
   assign out_d2 = col_d[1];
   assign out_d3 = col_d[2];
   assign out_d4 = col_d[3];

endmodule

// File: tb/tb_idct4_transpose_buf.sv
// Self-checking bench for idct4_transpose_buf. A reference model holds
// complete blocks in a queue and serves columns from the head block.

module tb_idct4_transpose_buf;
   import idct_pkg::*;

   localparam int DW = IDCT_DATA_W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_d1, out_d2, out_d3, out_d4;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          sat_pulse;

   always #5 clk = ~clk;

   idct4_transpose_buf #(
      .DATA_W (IDCT_DATA_W),
      .CLIP_W (IDCT_CLIP_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_d1    (out_d1),
      .out_d2    (out_d2),
      .out_d3    (out_d3),
      .out_d4    (out_d4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .sat_pulse (sat_pulse)
   );

   typedef logic [DW-1:0] blk_t [16];

   int            errors = 0;
   int            checks = 0;
   blk_t          blkq [$];
   blk_t          part;
   int            pcnt = 0;
   int            rcol = 0;
   logic          exp_sat = 1'b0;
   int            dut_beats = 0;

   function automatic logic [DW-1:0] ref_clip(input logic [DW-1:0] x);
      longint v, hi, lo;
      v  = longint'($signed(x));
      hi = (longint'(1) << (IDCT_CLIP_W - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
      return DW'(v);
   endfunction

   function automatic logic ref_clipped(input logic [DW-1:0] x);
      return ref_clip(x) !== x;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      case ($urandom_range(0, 2))
         0:       return DW'($urandom_range(0, 99999)) - DW'(50000);
         1:       return DW'($urandom);
         default: return DW'($urandom_range(0, 600)) - DW'(300);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model,
   // then advance the model across the rising edge.
   task automatic step(input logic vin, input logic [DW-1:0] din,
                       input logic rdy, output logic acc);
      logic ev, eir, bt;
      logic [DW-1:0] ed [4];
      @(negedge clk);
      in_valid  = vin;
      in_data   = din;
      out_ready = rdy;
      #1;
      ev  = blkq.size() > 0;
      eir = blkq.size() < 2;
      for (int r = 0; r < 4; r++) ed[r] = ev ? blkq[0][r*4 + rcol] : '0;
      chk("in_ready",  DW'(in_ready),  DW'(eir));
      chk("out_valid", DW'(out_valid), DW'(ev));
      chk("out_last",  DW'(out_last),  DW'(ev && rcol == 3));
      chk("sat_pulse", DW'(sat_pulse), DW'(exp_sat));
      chk("out_d1", out_d1, ed[0]);
      chk("out_d2", out_d2, ed[1]);
      chk("out_d3", out_d3, ed[2]);
      chk("out_d4", out_d4, ed[3]);
      if (out_valid && out_ready) dut_beats++;
      acc = vin && eir;
      bt  = ev && rdy;
      @(posedge clk);
      exp_sat = acc && ref_clipped(din);
      if (bt) begin
         rcol++;
         if (rcol == 4) begin
            void'(blkq.pop_front());
            rcol = 0;
         end
      end
      if (acc) begin
         part[pcnt] = ref_clip(din);
         pcnt++;
         if (pcnt == 16) begin
            blkq.push_back(part);
            pcnt = 0;
         end
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic rdy);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
         step(1'b1, d, rdy, acc);
         n++;
      end
      if (!acc) chk("send_timeout", DW'(acc), DW'(1));
   endtask

   task automatic drain(input int n, input logic rdy);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, rdy, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_in_ready",  DW'(in_ready),  DW'(1));
      chk("rst_out_last",  DW'(out_last),  DW'(0));
      chk("rst_sat_pulse", DW'(sat_pulse), DW'(0));
      chk("rst_out_d1", out_d1, '0);
      chk("rst_out_d2", out_d2, '0);
      chk("rst_out_d3", out_d3, '0);
      chk("rst_out_d4", out_d4, '0);
      blkq.delete();
      pcnt    = 0;
      rcol    = 0;
      exp_sat = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic          acc;
      logic [DW-1:0] bp [48];
      int            ptr;
      int            guard;
      logic          pat [4];

      do_reset();

      // Single block, values 0..15
      for (int i = 0; i < 16; i++) send(DW'(i), 1'b1);
      drain(6, 1'b1);

      // Clipping at and beyond both limits
      send(DW'(40000), 1'b1);
      send(DW'(-40000), 1'b1);
      send(DW'(32767), 1'b1);
      send(DW'(-32768), 1'b1);
      for (int i = 0; i < 12; i++) send(DW'($urandom_range(0, 200)), 1'b1);
      drain(6, 1'b1);

      // Back-pressure: three blocks against a stalled reader
      for (int i = 0; i < 48; i++) bp[i] = rnd_data();
      ptr = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, bp[ptr], 1'b0, acc);
         if (acc) ptr++;
      end
      chk("bp_accepted", DW'(ptr), DW'(32));
      guard = 0;
      while (ptr < 48 && guard < 200) begin
         step(1'b1, bp[ptr], 1'b1, acc);
         if (acc) ptr++;
         guard++;
      end
      chk("bp_all_sent", DW'(ptr), DW'(48));
      drain(16, 1'b1);

      // Hold under stall: reader pattern 1,0,0,1
      for (int i = 0; i < 32; i++) send(rnd_data(), 1'b0);
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      for (int i = 0; i < 48; i++) step(1'b0, '0, pat[i % 4], acc);
      drain(8, 1'b1);

      // Continuous stream: 8 blocks back to back
      dut_beats = 0;
      for (int i = 0; i < 128; i++) send(rnd_data(), 1'b1);
      drain(8, 1'b1);
      chk("cont_beats", DW'(dut_beats), DW'(32));

      // Reset while block 0 drains and block 1 is partly written
      for (int i = 0; i < 16; i++) send(rnd_data(), 1'b0);
      for (int i = 0; i < 8; i++) send(rnd_data(), 1'b0);
      send(rnd_data(), 1'b1);
      send(rnd_data(), 1'b1);
      do_reset();
      for (int i = 0; i < 16; i++) send(rnd_data(), 1'b1);
      drain(6, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
